// File: rtl/bmc_bit_decoder.sv
// BMC lighthouse bit decoder: classifies edge intervals into half/full bits, one bit strobe per decoded bit.
// Optional `BMC_ERROR_COUNT_EN adds err_count, a saturating count of frames ending in error.
module bmc_bit_decoder #(
  parameter int HALF_MIN       = 5,
  parameter int HALF_MAX       = 11,
  parameter int FULL_MIN       = 12,
  parameter int FULL_MAX       = 20,
  parameter int ENV_ACTIVE_LOW = 1
) (
  input  logic        clk_96MHz,
  input  logic        reset_n,
  input  logic        d_in_0,
  input  logic        d_in_1,
  input  logic        e_in,
  output logic        bit_out,
  output logic        bit_valid,
  output logic [9:0]  bit_count,
  output logic        frame_done,
  output logic        frame_error,
  output logic [15:0] env_width
`ifdef BMC_ERROR_COUNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_RUN, S_ERROR} state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic        r_pending;
  logic        r_err;
  logic [15:0] r_acc;

  logic w_env_act;
  logic w_edge;
  logic w_short;
  logic w_long;
  logic w_stall;
  logic w_end_err;

  assign w_env_act = (ENV_ACTIVE_LOW != 0) ? ~e_in : e_in;
  assign w_edge    = d_in_0 ^ d_in_1;
  assign w_short   = (r_cnt >= 8'(HALF_MIN)) && (r_cnt <= 8'(HALF_MAX));
  assign w_long    = (r_cnt >= 8'(FULL_MIN)) && (r_cnt <= 8'(FULL_MAX));
  assign w_stall   = r_cnt > 8'(FULL_MAX);
  // A half-bit still waiting for its partner at envelope end is a truncated bit.
  assign w_end_err = r_err | r_pending;

  // Edge-to-edge interval: counts clks since the last edge, value at an edge is the interval.
  always_ff @(posedge clk_96MHz) begin
    if (!reset_n) begin
      r_cnt <= 8'd0;
    end else if (w_edge) begin
      r_cnt <= 8'd1;
    end else if (r_cnt != 8'hFF) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_96MHz) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pending   <= 1'b0;
      r_err       <= 1'b0;
      r_acc       <= 16'd0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      bit_count   <= 10'd0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      env_width   <= 16'd0;
`ifdef BMC_ERROR_COUNT_EN
      err_count   <= 8'd0;
`endif
    end else begin
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_env_act) begin
            r_state   <= S_SYNC;
            r_acc     <= 16'd1;
            bit_count <= 10'd0;
            r_pending <= 1'b0;
            r_err     <= 1'b0;
          end
        end
        default: begin
          // Envelope end wins over anything else seen in the same cycle, including a completing edge.
          if (!w_env_act) begin
            r_state     <= S_IDLE;
            r_pending   <= 1'b0;
            frame_done  <= 1'b1;
            frame_error <= w_end_err;
            env_width   <= r_acc;
`ifdef BMC_ERROR_COUNT_EN
            if (w_end_err && (err_count != 8'hFF)) begin
              err_count <= err_count + 8'd1;
            end
`endif
          end else begin
            if (r_acc != 16'hFFFF) begin
              r_acc <= r_acc + 16'd1;
            end
            case (r_state)
              S_SYNC: begin
                if (w_edge) begin
                  r_state <= S_RUN;
                end
              end
              S_RUN: begin
                if (w_edge) begin
                  if (w_long && !r_pending) begin
                    bit_valid <= 1'b1;
                    bit_out   <= 1'b0;
                    if (bit_count != 10'h3FF) bit_count <= bit_count + 10'd1;
                  end else if (w_short && !r_pending) begin
                    r_pending <= 1'b1;
                  end else if (w_short && r_pending) begin
                    bit_valid <= 1'b1;
                    bit_out   <= 1'b1;
                    r_pending <= 1'b0;
                    if (bit_count != 10'h3FF) bit_count <= bit_count + 10'd1;
                  end else begin
                    r_state <= S_ERROR;
                    r_err   <= 1'b1;
                  end
                end else if (w_stall) begin
                  r_state <= S_ERROR;
                  r_err   <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bmc_bit_decoder.sv
// Directed bench for bmc_bit_decoder: hand-computed bit sequences, boundaries and frame statistics.
module tb_bmc_bit_decoder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        d_in_0, d_in_1, e_in;
  logic        bit_out, bit_valid, frame_done, frame_error;
  logic [9:0]  bit_count;
  logic [15:0] env_width;
`ifdef BMC_ERROR_COUNT_EN
  logic [7:0]  err_count;
`endif

  int   n_vec = 0;
  int   n_err = 0;
  int   pulses = 0;
  int   act = 0;
  logic line = 1'b0;

  bmc_bit_decoder dut (
    .clk_96MHz(clk), .reset_n(reset_n), .d_in_0(d_in_0), .d_in_1(d_in_1), .e_in(e_in),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_count(bit_count),
    .frame_done(frame_done), .frame_error(frame_error), .env_width(env_width)
`ifdef BMC_ERROR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  // One clock: present the line level (previous level becomes d_in_1) and envelope, then sample after the edge.
  task automatic cyc(input logic lv, input logic env);
    d_in_1 = d_in_0;
    d_in_0 = lv;
    e_in   = env;
    if (env == 1'b0) act++;
    @(posedge clk);
    #1;
    if (bit_valid === 1'b1) pulses++;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cyc(line, 1'b0);
  endtask

  task automatic tog(input logic env);
    line = ~line;
    cyc(line, env);
  endtask

  // Next edge lands exactly n clks after the previous one.
  task automatic edge_after(input int n);
    quiet(n - 1);
    tog(1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) tog(1'b0);
    n_vec++; if ({bit_valid, bit_out, frame_done, frame_error} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags got %b want 0000", {bit_valid, bit_out, frame_done, frame_error});
    end
    n_vec++; if ({bit_count, env_width} !== 26'd0) begin
      n_err++; $display("FAIL reset_counts got count=%0d width=%0d want 0/0", bit_count, env_width);
    end
    reset_n = 1'b1;
    cyc(line, 1'b1);
    cyc(line, 1'b1);
    n_vec++; if ({bit_valid, frame_done} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle got %b want 00", {bit_valid, frame_done});
    end
  endtask

  task automatic test_nominal();
    int p0;
    act = 0;
    cyc(line, 1'b0);
    quiet(2);
    tog(1'b0);
    n_vec++; if (bit_valid !== 1'b0) begin
      n_err++; $display("FAIL nom_sync_edge bit_valid=%b want 0", bit_valid);
    end
    p0 = pulses;
    edge_after(16);
    n_vec++; if ({bit_valid, bit_out} !== 2'b10) begin
      n_err++; $display("FAIL nom_bit0 valid/out=%b want 10", {bit_valid, bit_out});
    end
    edge_after(8);
    n_vec++; if (bit_valid !== 1'b0) begin
      n_err++; $display("FAIL nom_half bit_valid=%b want 0", bit_valid);
    end
    edge_after(8);
    n_vec++; if ({bit_valid, bit_out} !== 2'b11) begin
      n_err++; $display("FAIL nom_bit1 valid/out=%b want 11", {bit_valid, bit_out});
    end
    edge_after(16);
    n_vec++; if ({bit_valid, bit_out} !== 2'b10) begin
      n_err++; $display("FAIL nom_bit2 valid/out=%b want 10", {bit_valid, bit_out});
    end
    edge_after(8);
    edge_after(8);
    n_vec++; if ({bit_valid, bit_out} !== 2'b11) begin
      n_err++; $display("FAIL nom_bit3 valid/out=%b want 11", {bit_valid, bit_out});
    end
    quiet(3);
    n_vec++; if ((pulses - p0) !== 4 || bit_count !== 10'd4) begin
      n_err++; $display("FAIL nom_count pulses=%0d count=%0d want 4/4", pulses - p0, bit_count);
    end
    cyc(line, 1'b1);
    n_vec++; if ({frame_done, frame_error} !== 2'b10 || env_width !== 16'(act)) begin
      n_err++; $display("FAIL nom_end done/err=%b width=%0d want 10/%0d", {frame_done, frame_error}, env_width, act);
    end
    cyc(line, 1'b1);
    n_vec++; if (frame_done !== 1'b0 || bit_count !== 10'd4 || env_width !== 16'(act)) begin
      n_err++; $display("FAIL nom_hold done=%b count=%0d width=%0d want 0/4/%0d", frame_done, bit_count, env_width, act);
    end
  endtask

  task automatic test_half_then_long(input int exp_errs);
    int p0;
    cyc(line, 1'b0);
    tog(1'b0);
    p0 = pulses;
    edge_after(8);
    edge_after(16);
    edge_after(16);
    edge_after(8);
    edge_after(8);
    n_vec++; if ((pulses - p0) !== 0) begin
      n_err++; $display("FAIL err_no_bits pulses=%0d want 0", pulses - p0);
    end
    cyc(line, 1'b1);
    n_vec++; if ({frame_done, frame_error} !== 2'b11 || bit_count !== 10'd0) begin
      n_err++; $display("FAIL err_end done/err=%b count=%0d want 11/0", {frame_done, frame_error}, bit_count);
    end
`ifdef BMC_ERROR_COUNT_EN
    n_vec++; if (err_count !== 8'(exp_errs)) begin
      n_err++; $display("FAIL err_count1 got %0d want %0d", err_count, exp_errs);
    end
`endif
    cyc(line, 1'b1);
  endtask

  task automatic test_boundaries();
    cyc(line, 1'b0);
    tog(1'b0);
    edge_after(20);
    n_vec++; if ({bit_valid, bit_out} !== 2'b10) begin
      n_err++; $display("FAIL bnd_full20 valid/out=%b want 10", {bit_valid, bit_out});
    end
    edge_after(12);
    n_vec++; if ({bit_valid, bit_out} !== 2'b10) begin
      n_err++; $display("FAIL bnd_full12 valid/out=%b want 10", {bit_valid, bit_out});
    end
    edge_after(5);
    edge_after(11);
    n_vec++; if ({bit_valid, bit_out} !== 2'b11) begin
      n_err++; $display("FAIL bnd_half5_11 valid/out=%b want 11", {bit_valid, bit_out});
    end
    edge_after(11);
    edge_after(5);
    n_vec++; if ({bit_valid, bit_out} !== 2'b11) begin
      n_err++; $display("FAIL bnd_half11_5 valid/out=%b want 11", {bit_valid, bit_out});
    end
    cyc(line, 1'b1);
    n_vec++; if ({frame_done, frame_error} !== 2'b10 || bit_count !== 10'd4) begin
      n_err++; $display("FAIL bnd_end done/err=%b count=%0d want 10/4", {frame_done, frame_error}, bit_count);
    end
    cyc(line, 1'b1);
    cyc(line, 1'b0);
    tog(1'b0);
    edge_after(4);
    edge_after(16);
    n_vec++; if (bit_valid !== 1'b0) begin
      n_err++; $display("FAIL bnd_short4 bit_valid=%b want 0", bit_valid);
    end
    cyc(line, 1'b1);
    n_vec++; if ({frame_done, frame_error} !== 2'b11) begin
      n_err++; $display("FAIL bnd_short4_end done/err=%b want 11", {frame_done, frame_error});
    end
    cyc(line, 1'b1);
  endtask

  task automatic test_stall(input int exp_errs);
    cyc(line, 1'b0);
    tog(1'b0);
    quiet(20);
    cyc(line, 1'b1);
    n_vec++; if ({frame_done, frame_error} !== 2'b10) begin
      n_err++; $display("FAIL stall20 done/err=%b want 10", {frame_done, frame_error});
    end
    cyc(line, 1'b1);
    cyc(line, 1'b0);
    tog(1'b0);
    quiet(21);
    cyc(line, 1'b1);
    n_vec++; if ({frame_done, frame_error} !== 2'b11) begin
      n_err++; $display("FAIL stall21 done/err=%b want 11", {frame_done, frame_error});
    end
`ifdef BMC_ERROR_COUNT_EN
    n_vec++; if (err_count !== 8'(exp_errs)) begin
      n_err++; $display("FAIL err_count3 got %0d want %0d", err_count, exp_errs);
    end
`endif
    cyc(line, 1'b1);
  endtask

  task automatic test_simultaneous_end();
    cyc(line, 1'b0);
    tog(1'b0);
    edge_after(16);
    quiet(15);
    tog(1'b1);
    n_vec++; if ({frame_done, bit_valid, frame_error} !== 3'b100 || bit_count !== 10'd1) begin
      n_err++; $display("FAIL simul_end done/valid/err=%b count=%0d want 100/1", {frame_done, bit_valid, frame_error}, bit_count);
    end
    cyc(line, 1'b1);
  endtask

  task automatic test_long_envelope();
    cyc(line, 1'b0);
    quiet(69999);
    cyc(line, 1'b1);
    n_vec++; if ({frame_done, frame_error} !== 2'b10 || env_width !== 16'hFFFF || bit_count !== 10'd0) begin
      n_err++; $display("FAIL long_env done/err=%b width=%0d count=%0d want 10/65535/0", {frame_done, frame_error}, env_width, bit_count);
    end
    cyc(line, 1'b1);
  endtask

  task automatic test_mid_reset();
    cyc(line, 1'b0);
    tog(1'b0);
    edge_after(16);
    edge_after(16);
    reset_n = 1'b0;
    cyc(line, 1'b0);
    reset_n = 1'b1;
    cyc(line, 1'b1);
    cyc(line, 1'b1);
    n_vec++; if ({frame_done, frame_error, bit_valid} !== 3'b000 || bit_count !== 10'd0 || env_width !== 16'd0) begin
      n_err++; $display("FAIL mid_reset flags=%b count=%0d width=%0d want 000/0/0", {frame_done, frame_error, bit_valid}, bit_count, env_width);
    end
`ifdef BMC_ERROR_COUNT_EN
    n_vec++; if (err_count !== 8'd0) begin
      n_err++; $display("FAIL mid_reset_errcnt got %0d want 0", err_count);
    end
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    d_in_0  = 1'b0;
    d_in_1  = 1'b0;
    e_in    = 1'b1;
    test_reset();
    test_nominal();
    test_half_then_long(1);
    test_boundaries();
    test_stall(3);
    test_simultaneous_end();
    test_long_envelope();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
